// File: rtl/btb_pkg.sv
// Shared types and helpers for the fully associative branch target buffer.
// Entry layout, counter encoding and the saturating counter step.
package btb_pkg;

  localparam int TAG_W   = 11;
  localparam int TAG_LSB = 2;
  localparam int CTR_W   = 2;

  localparam logic [CTR_W-1:0] CTR_SNT = 2'd0;
  localparam logic [CTR_W-1:0] CTR_WNT = 2'd1;
  localparam logic [CTR_W-1:0] CTR_WT  = 2'd2;
  localparam logic [CTR_W-1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[TAG_W+TAG_LSB-1:TAG_LSB];
  endfunction

  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] ctr,
                                                input logic             taken);
    if (taken) begin
      return (ctr == CTR_ST) ? ctr : ctr + 1'b1;
    end
    return (ctr == CTR_SNT) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/btb_tag_match.sv
// One comparator per BTB entry: XNOR each stored tag bit against the probe and
// AND-reduce, qualified by the entry's valid bit.
module btb_tag_match #(
  parameter int TAG_W = 11
) (
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] probe_i,
  output logic             match_o
);

  logic [TAG_W-1:0] bit_eq;

  assign bit_eq  = ~(tag_i ^ probe_i);
  assign match_o = valid_i & (&bit_eq);

endmodule

// File: rtl/btb_predictor.sv
// Fully associative BTB: combinational fetch-side lookup, EX-side update or
// round-robin allocation on the rising edge, synchronous flush, async reset.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int               ENTRIES  = 8,
  parameter int               IDX_W    = 3,
  parameter logic [CTR_W-1:0] CTR_INIT = CTR_WT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      fetch_pc_i,
  output logic             predict_hit_o,
  output logic             predict_taken_o,
  output logic [31:0]      predict_target_o,
  output logic [IDX_W-1:0] hit_index_o,
  input  logic             update_en_i,
  input  logic [31:0]      update_pc_i,
  input  logic [31:0]      update_target_i,
  input  logic             update_taken_i,
  input  logic             flush_all_i,
  output logic [IDX_W-1:0] alloc_ptr_o
);

  btb_entry_t       ent_q [ENTRIES];
  btb_entry_t       ent_d [ENTRIES];
  logic [IDX_W-1:0] alloc_ptr_q, alloc_ptr_d;

  logic [TAG_W-1:0]   fetch_tag, upd_tag;
  logic [ENTRIES-1:0] look_match, upd_match;
  logic               unused_pc_bits;

  assign fetch_tag      = pc_tag(fetch_pc_i);
  assign upd_tag        = pc_tag(update_pc_i);
  assign unused_pc_bits = ^{fetch_pc_i[31:TAG_W+TAG_LSB], fetch_pc_i[TAG_LSB-1:0],
                            update_pc_i[31:TAG_W+TAG_LSB], update_pc_i[TAG_LSB-1:0]};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_match
    btb_tag_match #(.TAG_W(TAG_W)) u_look (
      .valid_i (ent_q[g].valid),
      .tag_i   (ent_q[g].tag),
      .probe_i (fetch_tag),
      .match_o (look_match[g])
    );
    btb_tag_match #(.TAG_W(TAG_W)) u_upd (
      .valid_i (ent_q[g].valid),
      .tag_i   (ent_q[g].tag),
      .probe_i (upd_tag),
      .match_o (upd_match[g])
    );
  end

  // Descending scans: the last assignment wins, so the lowest index takes priority.
  logic             look_hit;
  logic [IDX_W-1:0] look_idx;
  logic             upd_hit;
  logic [IDX_W-1:0] upd_idx;
  logic             has_free;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    look_hit = 1'b0;
    look_idx = '0;
    upd_hit  = 1'b0;
    upd_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (look_match[i]) begin
        look_hit = 1'b1;
        look_idx = IDX_W'(i);
      end
      if (upd_match[i]) begin
        upd_hit = 1'b1;
        upd_idx = IDX_W'(i);
      end
      if (!ent_q[i].valid) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    predict_hit_o    = look_hit;
    predict_taken_o  = 1'b0;
    predict_target_o = '0;
    hit_index_o      = '0;
    if (look_hit) begin
      predict_taken_o  = ent_q[look_idx].ctr[CTR_W-1];
      predict_target_o = ent_q[look_idx].target;
      hit_index_o      = look_idx;
    end
  end

  assign alloc_ptr_o = alloc_ptr_q;

  logic [IDX_W-1:0] victim;

  always_comb begin
    ent_d       = ent_q;
    alloc_ptr_d = alloc_ptr_q;
    victim      = has_free ? free_idx : alloc_ptr_q;
    if (flush_all_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_d[i].valid = 1'b0;
      end
      alloc_ptr_d = '0;
    end else if (update_en_i) begin
      if (upd_hit) begin
        ent_d[upd_idx].target = update_target_i;
        ent_d[upd_idx].ctr    = ctr_step(ent_q[upd_idx].ctr, update_taken_i);
      end else if (update_taken_i) begin
        ent_d[victim].valid  = 1'b1;
        ent_d[victim].tag    = upd_tag;
        ent_d[victim].target = update_target_i;
        ent_d[victim].ctr    = CTR_INIT;
        // An invalid slot that happens to sit at the pointer still counts as consuming it.
        if (victim == alloc_ptr_q) begin
          alloc_ptr_d = (alloc_ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : alloc_ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      alloc_ptr_q <= '0;
    end else begin
      ent_q       <= ent_d;
      alloc_ptr_q <= alloc_ptr_d;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed bench for btb_predictor against an array-based reference model.
module tb_btb_predictor;

  localparam int N = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] fetch_pc_i;
  logic        predict_hit_o;
  logic        predict_taken_o;
  logic [31:0] predict_target_o;
  logic [2:0]  hit_index_o;
  logic        update_en_i;
  logic [31:0] update_pc_i;
  logic [31:0] update_target_i;
  logic        update_taken_i;
  logic        flush_all_i;
  logic [2:0]  alloc_ptr_o;

  btb_predictor #(.ENTRIES(N), .IDX_W(3), .CTR_INIT(2'd2)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .fetch_pc_i       (fetch_pc_i),
    .predict_hit_o    (predict_hit_o),
    .predict_taken_o  (predict_taken_o),
    .predict_target_o (predict_target_o),
    .hit_index_o      (hit_index_o),
    .update_en_i      (update_en_i),
    .update_pc_i      (update_pc_i),
    .update_target_i  (update_target_i),
    .update_taken_i   (update_taken_i),
    .flush_all_i      (flush_all_i),
    .alloc_ptr_o      (alloc_ptr_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain arrays, tags are PC bits 12:2.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          m_ptr;

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> 2) % 2048;
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_tag[i] == tag_of(pc)) return i;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic m_update(input bit en, input logic [31:0] pc, input logic [31:0] tgt,
                          input bit taken, input bit flush);
    int k;
    int v;
    if (flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_ptr = 0;
    end else if (en) begin
      k = m_find(pc);
      if (k >= 0) begin
        m_tgt[k] = tgt;
        if (taken) m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
        else       m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
      end else if (taken) begin
        v = -1;
        for (int i = 0; i < N; i++) if (!m_valid[i] && v < 0) v = i;
        if (v < 0) v = m_ptr;
        m_valid[v] = 1; m_tag[v] = tag_of(pc); m_tgt[v] = tgt; m_ctr[v] = 2;
        if (v == m_ptr) m_ptr = (m_ptr + 1) % N;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int k;
    k = m_find(fetch_pc_i);
    chk({tag, "_hit"},   {31'd0, predict_hit_o},   (k >= 0) ? 32'd1 : 32'd0);
    chk({tag, "_taken"}, {31'd0, predict_taken_o}, (k >= 0 && m_ctr[k] >= 2) ? 32'd1 : 32'd0);
    chk({tag, "_tgt"},   predict_target_o,         (k >= 0) ? m_tgt[k] : 32'd0);
    chk({tag, "_idx"},   {29'd0, hit_index_o},     (k >= 0) ? k : 0);
    chk({tag, "_ptr"},   {29'd0, alloc_ptr_o},     m_ptr);
  endtask

  // Drive one cycle's inputs, check the pre-edge lookup, then clock the model.
  task automatic cyc(input string tag, input logic [31:0] fpc, input bit en,
                     input logic [31:0] upc, input logic [31:0] tgt,
                     input bit taken, input bit flush);
    fetch_pc_i = fpc; update_en_i = en; update_pc_i = upc;
    update_target_i = tgt; update_taken_i = taken; flush_all_i = flush;
    #2;
    check_outputs(tag);
    @(posedge clk_i);
    m_update(en, upc, tgt, taken, flush);
    #1;
  endtask

  task automatic probe(input string tag, input logic [31:0] fpc);
    cyc(tag, fpc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  logic [31:0] rpc, rfpc;

  initial begin
    m_reset();
    rst_ni = 1'b0;
    fetch_pc_i = 32'h0040_0010; update_en_i = 1'b0; update_pc_i = '0;
    update_target_i = '0; update_taken_i = 1'b0; flush_all_i = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Allocate, then watch the counter walk down, saturate, and back up.
    cyc("alloc", 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0);
    probe("alloc_look", 32'h0040_0010);
    chk("alloc_idx0", {29'd0, hit_index_o}, 32'd0);
    for (int i = 0; i < 3; i++)
      cyc("nt", 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("tk", 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0200 + i, 1'b1, 1'b0);
    probe("sat_look", 32'h0040_0010);

    // Nine distinct taken branches: the ninth evicts entry 0.
    cyc("fl", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++)
      cyc("fill", 32'h0040_1000, 1'b1, 32'h0040_1000 + 4 * i, 32'h0080_0000 + i, 1'b1, 1'b0);
    chk("fill_ptr", {29'd0, alloc_ptr_o}, 32'd1);
    probe("evict_first", 32'h0040_1000);
    chk("evict_first_miss", {31'd0, predict_hit_o}, 32'd0);
    probe("evict_ninth", 32'h0040_1020);
    chk("ninth_idx", {29'd0, hit_index_o}, 32'd0);
    chk("ninth_hit", {31'd0, predict_hit_o}, 32'd1);

    // Aliasing on bits above the tag.
    cyc("fl2", 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    cyc("al", 32'h0, 1'b1, 32'h0040_0010, 32'h0000_1234, 1'b1, 1'b0);
    probe("alias", 32'h0040_2010);
    chk("alias_hit", {31'd0, predict_hit_o}, 32'd1);
    probe("alias_miss", 32'h0040_0014);

    // Flush wins over a simultaneous allocating update.
    cyc("flupd", 32'h0040_0010, 1'b1, 32'h0040_0444, 32'h0000_5555, 1'b1, 1'b1);
    probe("after_flush", 32'h0040_0444);
    chk("after_flush_ptr", {29'd0, alloc_ptr_o}, 32'd0);

    // Randomized traffic over a small PC pool with occasional alias bits.
    for (int n = 0; n < 600; n++) begin
      rpc  = 32'h0040_0000 + ($urandom_range(0, 13) << 2) + (($urandom_range(0, 7) == 0) ? 32'h2000 : 32'h0);
      rfpc = 32'h0040_0000 + ($urandom_range(0, 13) << 2);
      cyc("rnd", rfpc, ($urandom_range(0, 9) < 7), rpc, $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
    end

    // Asynchronous reset between edges clears outputs immediately.
    cyc("pre_rst", 32'h0040_0500, 1'b1, 32'h0040_0500, 32'h0000_0777, 1'b1, 1'b0);
    fetch_pc_i = 32'h0040_0500; update_en_i = 1'b0;
    #1;
    chk("pre_rst_hit", {31'd0, predict_hit_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    m_reset();
    chk("async_rst_hit", {31'd0, predict_hit_o}, 32'd0);
    chk("async_rst_tgt", predict_target_o, 32'd0);
    chk("async_rst_ptr", {29'd0, alloc_ptr_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    probe("post_rst", 32'h0040_0500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Small, fully associative branch target buffer in the IF stage of the redirection pipeline.
- Each entry holds an 11-bit PC tag, a 32-bit target and a 2-bit saturating direction counter.
- Fetch side: combinational tag match per entry (11-bit equality, AND-reduced) gives a next-PC prediction.
- EX side: resolved branches update or allocate entries on the clock edge.

Parameters:
- ENTRIES, 8, number of BTB entries (power of two, 2..16).
- IDX_W, 3, log2(ENTRIES).
- TAG_W, 11, tag width; tag = PC[TAG_W+1:2].
- CTR_INIT, 2, counter value loaded on allocation (weakly taken).

Ports:
- Clock  in  1  pipeline clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Fetch_PC  in  32  current IF-stage PC.
- Predict_Hit  out  1  tag match on a valid entry.
- Predict_Taken  out  1  Predict_Hit & counter[1].
- Predict_Target  out  32  target of the hit entry; 0 when no hit.
- Hit_Index  out  IDX_W  index of the hit entry; 0 when no hit.
- Update_En  in  1  EX stage resolved a branch/jump this cycle.
- Update_PC  in  32  PC of the resolved instruction.
- Update_Target  in  32  resolved target.
- Update_Taken  in  1  resolved direction.
- Flush_All  in  1  synchronous invalidate of all entries.
- Alloc_Ptr  out  IDX_W  round-robin victim pointer (debug/verification).

Behaviour:
- Reset (async, Reset_n=0):
  - all valid=0, tags/targets/counters=0, Alloc_Ptr=0.
  - Outputs are therefore Predict_Hit=0, Predict_Taken=0, Predict_Target=0, Hit_Index=0.
  - Reset asserted mid-update discards that update.
- Lookup (combinational, 0 cycles):
  - match[i] = valid[i] & AND over all TAG_W bits of (tag[i][b] XNOR Fetch_PC[b+2]).
  - At most one match exists by construction. If several match, the lowest index wins.
  - Outputs are taken from the winning entry.
- Update (rising edge, Update_En=1): tag u = Update_PC[TAG_W+1:2].
  - Hit on entry k:
    - target[k] <= Update_Target.
    - Counter saturates up if Update_Taken, else down (0..3).
    - Alloc_Ptr unchanged.
  - Miss and Update_Taken=1:
    - Victim is the lowest-index invalid entry if any exists, else Alloc_Ptr.
    - Victim gets valid=1, tag=u, target=Update_Target, counter=CTR_INIT.
    - Alloc_Ptr advances (wraps ENTRIES-1 -> 0) only when the victim was Alloc_Ptr.
  - Miss and Update_Taken=0: no state change (no allocation for not-taken).
- Flush_All=1: all valid <= 0 and Alloc_Ptr <= 0 on the edge. This overrides a simultaneous Update_En.
- Same-cycle lookup/update of the same entry: lookup sees the pre-edge contents. There is no bypass.
- Update_En=0: no state change. Fetch_PC is never registered here.
- Counter encoding: 0 strongly not-taken, 1 weakly not-taken, 2 weakly taken, 3 strongly taken.

Decomposition:
- Shared package btb_pkg holds:
  - constants TAG_LSB=2, CTR_W=2, CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3;
  - the entry struct (valid, tag, target, ctr).
- One natural sub-module, btb_tag_match: one per entry.
  - Inputs: valid, stored tag, probe tag. Output: match.
  - Implemented as TAG_W XNORs into a single AND reduction.
  - It is instantiated for the lookup port and separately for the update port.
- The saturating counter step is a package function, not a module.

Test Plan:
1. Reset with Fetch_PC=0x00400010 -> Predict_Hit=0, Predict_Target=0, Alloc_Ptr=0.
2. Update_En=1, Update_PC=0x00400010, Update_Target=0x00400100, Update_Taken=1, then Fetch_PC=0x00400010 next cycle:
   - Predict_Hit=1, Predict_Taken=1 (ctr=2), Predict_Target=0x00400100, Hit_Index=0.
3. Two not-taken updates to that PC:
   - Counter goes 2->1->0 and Predict_Taken=0 while Predict_Hit=1.
   - A third not-taken keeps ctr=0. Four taken updates saturate the counter at 3.
4. Nine distinct taken branches with ENTRIES=8:
   - Entries 0..7 fill, then the 9th replaces entry 0 (Alloc_Ptr 0->1).
   - Lookup of the 1st PC misses; lookup of the 9th PC hits at index 0.
5. Alias check: an entry at PC 0x00400010, probed with Fetch_PC=0x00402010 (same tag, bits 12:2 equal) -> hit, documented aliasing.
   - Probe 0x00400014 -> miss.
6. Flush_All=1 together with Update_En=1 (taken, new PC) -> all entries invalid, no allocation, Alloc_Ptr=0.
   - Also: Reset_n pulsed low between edges clears outputs immediately, without waiting for a clock edge.
